// File: rtl/phase_processor_n.sv
// phase_processor_n
//   Takes the time-multiplexed magnitude/phase stream from the CORDIC (one
//   sample per channel per frame, channel 0 first) and publishes per-channel
//   magnitude and reference-referred phase:
//     phase[k] - mult[k]*phase[0]   (two's-complement wrap at +/-pi)
//   Results are boxcar-averaged over 2^avg_log2 complete frames.
//
// Ports
//   sys_clk, sys_rst   clock, synchronous active-high reset
//   mag_in, phase_in   sample data, qualified by strobe_in
//   strobe_in          one sample per pulse (may be asserted every cycle)
//   first_in           with strobe_in: this sample is channel 0 (resyncs)
//   mult_factors       harmonic multiplier for ch k at [(k-1)*MULT_W +: MULT_W]
//   avg_log2           averaging depth, clamped to AVG_MAX, taken at block start
//   mags, phases       published results, ch k at [k*W +: W]
//   strobe_out         one-cycle pulse in the cycle mags/phases change
//   frame_err          one-cycle pulse when a partial frame is discarded
//
// Handshake: strobe_in is a valid with no ready; every qualified sample is
// consumed the cycle it is presented, so the pipeline never stalls.
//
// Pipeline (strobe_in sampled at edge E1):
//   E1  channel tracking, reference phase latch, sample captured
//   E2  single shared multiplier: prod = phase[0]*mult[k] (mod 2^PH_W)
//   E3  diff = phase - prod; frame buffer write, or on the last channel the
//       whole frame is folded into the accumulators (and published when the
//       block is complete). strobe_out is therefore high 3 cycles after the
//       last channel's strobe_in.
module phase_processor_n #(
   parameter int N_CH    = 4,
   parameter int MAG_W   = 21,
   parameter int PH_W    = 22,
   parameter int MULT_W  = 4,
   parameter int AVG_MAX = 8
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst,
   input  logic [MAG_W-1:0]           mag_in,
   input  logic [PH_W-1:0]            phase_in,
   input  logic                       strobe_in,
   input  logic                       first_in,
   input  logic [(N_CH-1)*MULT_W-1:0] mult_factors,
   input  logic [3:0]                 avg_log2,
   output logic [N_CH*MAG_W-1:0]      mags,
   output logic [N_CH*PH_W-1:0]       phases,
   output logic                       strobe_out,
   output logic                       frame_err
);

   localparam int CW  = $clog2(N_CH);
   localparam int AMW = MAG_W + AVG_MAX;
   localparam int APW = PH_W + AVG_MAX;
   localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);
   localparam logic [3:0]    AVG_LIM = 4'(AVG_MAX);

   // ---------------- input stage ----------------
   logic [CW-1:0]      cnt;
   logic [CW-1:0]      ch_eff;
   logic               accept;
   logic               is_last;
   logic               is_pub;
   logic [3:0]         avg_clamp;
   logic [3:0]         avg_cur;
   logic [AVG_MAX-1:0] in_frame;
   logic [AVG_MAX:0]   blk_last;
   logic [PH_W-1:0]    ph0;

   logic               s1_v, s1_last, s1_pub;
   logic [CW-1:0]      s1_ch;
   logic [MAG_W-1:0]   s1_mag;
   logic [PH_W-1:0]    s1_ph;
   logic [3:0]         s1_sh;

   always_comb begin
      accept    = strobe_in & (first_in | (cnt != '0));
      ch_eff    = first_in ? '0 : cnt;
      is_last   = (ch_eff == LAST_CH);
      avg_clamp = (avg_log2 > AVG_LIM) ? AVG_LIM : avg_log2;
      blk_last  = ({{AVG_MAX{1'b0}}, 1'b1} << avg_cur) - 1'b1;
      // Only complete frames are counted, and only channel N_CH-1 closes
      // a frame, so the block boundary can be decided right here.
      is_pub    = is_last && ({1'b0, in_frame} == blk_last);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cnt       <= '0;
         in_frame  <= '0;
         avg_cur   <= '0;
         ph0       <= '0;
         frame_err <= 1'b0;
         s1_v      <= 1'b0;
         s1_last   <= 1'b0;
         s1_pub    <= 1'b0;
         s1_ch     <= '0;
         s1_mag    <= '0;
         s1_ph     <= '0;
         s1_sh     <= '0;
      end else begin
         frame_err <= strobe_in & first_in & (cnt != '0);
         s1_v      <= accept;
         if (accept) begin
            cnt     <= is_last ? '0 : ch_eff + 1'b1;
            s1_ch   <= ch_eff;
            s1_mag  <= mag_in;
            s1_ph   <= phase_in;
            s1_last <= is_last;
            s1_pub  <= is_pub;
            s1_sh   <= avg_cur;
            if (ch_eff == '0) begin
               ph0 <= phase_in;
               // First frame of a block: the depth for the whole block.
               if (in_frame == '0)
                  avg_cur <= avg_clamp;
            end
            if (is_last)
               in_frame <= is_pub ? '0 : in_frame + 1'b1;
         end
      end
   end

   // ---------------- stage 1: shared multiplier ----------------
   logic [MULT_W-1:0]  mult_sel;
   logic               s2_v, s2_last, s2_pub;
   logic [CW-1:0]      s2_ch;
   logic [MAG_W-1:0]   s2_mag;
   logic [PH_W-1:0]    s2_ph;
   logic [PH_W-1:0]    s2_prod;
   logic [3:0]         s2_sh;

   always_comb begin
      mult_sel = '0;   // channel 0 is passed through unmodified
      for (int k = 1; k < N_CH; k++)
         if (s1_ch == CW'(k))
            mult_sel = mult_factors[(k-1)*MULT_W +: MULT_W];
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         s2_v    <= 1'b0;
         s2_last <= 1'b0;
         s2_pub  <= 1'b0;
         s2_ch   <= '0;
         s2_mag  <= '0;
         s2_ph   <= '0;
         s2_prod <= '0;
         s2_sh   <= '0;
      end else begin
         s2_v    <= s1_v;
         s2_last <= s1_last;
         s2_pub  <= s1_pub;
         s2_ch   <= s1_ch;
         s2_mag  <= s1_mag;
         s2_ph   <= s1_ph;
         s2_sh   <= s1_sh;
         // The low PH_W bits of an unsigned product equal those of the
         // signed(phase0) x unsigned(mult) product, which is all we keep.
         s2_prod <= PH_W'({{MULT_W{1'b0}}, ph0} * {{PH_W{1'b0}}, mult_sel});
      end
   end

   // ---------------- stage 2: difference, accumulate, publish ----------------
   // The current frame is held in frame_mag/frame_ph and only folded into the
   // accumulators once it is complete. A partial frame is therefore discarded
   // simply by never committing it; the next frame overwrites its entries.
   logic [MAG_W-1:0]        frame_mag [N_CH];
   logic signed [PH_W-1:0]  frame_ph  [N_CH];
   logic [AMW-1:0]          acc_mag   [N_CH];
   logic signed [APW-1:0]   acc_ph    [N_CH];
   logic [AMW-1:0]          sum_mag   [N_CH];
   logic signed [APW-1:0]   sum_ph    [N_CH];
   logic signed [PH_W-1:0]  diff;
   logic signed [APW-1:0]   diff_ext;
   logic [AMW-1:0]          mag_ext;

   always_comb begin
      diff     = s2_ph - s2_prod;
      diff_ext = APW'(diff);
      mag_ext  = AMW'(s2_mag);
      for (int k = 0; k < N_CH; k++) begin
         sum_mag[k] = acc_mag[k] + ((k == N_CH-1) ? mag_ext  : AMW'(frame_mag[k]));
         sum_ph[k]  = acc_ph[k]  + ((k == N_CH-1) ? diff_ext : APW'(frame_ph[k]));
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         strobe_out <= 1'b0;
         mags       <= '0;
         phases     <= '0;
         for (int k = 0; k < N_CH; k++) begin
            frame_mag[k] <= '0;
            frame_ph[k]  <= '0;
            acc_mag[k]   <= '0;
            acc_ph[k]    <= '0;
         end
      end else begin
         strobe_out <= s2_v & s2_last & s2_pub;
         if (s2_v) begin
            if (!s2_last) begin
               frame_mag[s2_ch] <= s2_mag;
               frame_ph[s2_ch]  <= diff;
            end else begin
               for (int k = 0; k < N_CH; k++) begin
                  if (s2_pub) begin
                     mags[k*MAG_W +: MAG_W] <= MAG_W'(sum_mag[k] >> s2_sh);
                     phases[k*PH_W +: PH_W] <= PH_W'(sum_ph[k] >>> s2_sh);
                     acc_mag[k] <= '0;
                     acc_ph[k]  <= '0;
                  end else begin
                     acc_mag[k] <= sum_mag[k];
                     acc_ph[k]  <= sum_ph[k];
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_phase_processor_n.sv
// tb_phase_processor_n
//   Directed and randomized stimulus for phase_processor_n. A frame-level
//   reference model (integer arithmetic, frame buffer, block accumulators)
//   predicts every publication and frame_err pulse and the cycle it appears.
module tb_phase_processor_n;

  localparam int N_CH    = 4;
  localparam int MAG_W   = 21;
  localparam int PH_W    = 22;
  localparam int MULT_W  = 4;
  localparam int AVG_MAX = 8;

  // ---------------- clock / reset ----------------
  logic                       sys_clk = 1'b0;
  logic                       sys_rst = 1'b1;
  logic [MAG_W-1:0]           mag_in = '0;
  logic [PH_W-1:0]            phase_in = '0;
  logic                       strobe_in = 1'b0;
  logic                       first_in = 1'b0;
  logic [(N_CH-1)*MULT_W-1:0] mult_factors = '0;
  logic [3:0]                 avg_log2 = '0;
  logic [N_CH*MAG_W-1:0]      mags;
  logic [N_CH*PH_W-1:0]       phases;
  logic                       strobe_out;
  logic                       frame_err;

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  phase_processor_n #(
    .N_CH(N_CH), .MAG_W(MAG_W), .PH_W(PH_W), .MULT_W(MULT_W), .AVG_MAX(AVG_MAX)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .mag_in(mag_in), .phase_in(phase_in),
    .strobe_in(strobe_in), .first_in(first_in), .mult_factors(mult_factors),
    .avg_log2(avg_log2), .mags(mags), .phases(phases),
    .strobe_out(strobe_out), .frame_err(frame_err)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  int                     pub_q[$];
  int                     err_q[$];
  logic [N_CH*MAG_W-1:0]  exp_mag_q[$];
  logic [N_CH*PH_W-1:0]   exp_ph_q[$];
  logic [N_CH*MAG_W-1:0]  hold_mag = '0;
  logic [N_CH*PH_W-1:0]   hold_ph  = '0;
  bit                     chk_en = 1'b0;

  int     m_cnt, m_nfr, m_avg;
  longint m_ph0;
  longint m_fm[N_CH], m_fp[N_CH], m_am[N_CH], m_ap[N_CH];

  function automatic longint sx(input logic [PH_W-1:0] p);
    return longint'($signed(p));
  endfunction

  function automatic longint wrap_ph(input longint v);
    longint m;
    m = v & ((longint'(1) << PH_W) - 1);
    if (m >= (longint'(1) << (PH_W-1))) m -= (longint'(1) << PH_W);
    return m;
  endfunction

  task automatic model_clear();
    m_cnt = 0; m_nfr = 0; m_avg = 0; m_ph0 = 0;
    for (int k = 0; k < N_CH; k++) begin
      m_fm[k] = 0; m_fp[k] = 0; m_am[k] = 0; m_ap[k] = 0;
    end
    pub_q.delete(); err_q.delete(); exp_mag_q.delete(); exp_ph_q.delete();
    hold_mag = '0; hold_ph = '0;
  endtask

  // Called when a sample is presented; it is sampled at edge cyc+1.
  task automatic model_step(input logic first, input logic [MAG_W-1:0] mag,
                            input logic [PH_W-1:0] ph);
    int ch;
    longint mult;
    logic [N_CH*MAG_W-1:0] em;
    logic [N_CH*PH_W-1:0]  ep;
    if (first && m_cnt != 0) err_q.push_back(cyc + 1);
    if (!first && m_cnt == 0) return;
    ch = first ? 0 : m_cnt;
    if (ch == 0) begin
      m_ph0 = sx(ph);
      if (m_nfr == 0) m_avg = (avg_log2 > AVG_MAX) ? AVG_MAX : int'(avg_log2);
    end
    mult = (ch == 0) ? 0 : longint'(mult_factors[(ch-1)*MULT_W +: MULT_W]);
    m_fm[ch] = longint'(mag);
    m_fp[ch] = wrap_ph(sx(ph) - m_ph0 * mult);
    if (ch == N_CH-1) begin
      for (int k = 0; k < N_CH; k++) begin
        m_am[k] += m_fm[k];
        m_ap[k] += m_fp[k];
      end
      m_nfr++;
      if (m_nfr == (1 << m_avg)) begin
        for (int k = 0; k < N_CH; k++) begin
          em[k*MAG_W +: MAG_W] = MAG_W'(m_am[k] >>> m_avg);
          ep[k*PH_W +: PH_W]   = PH_W'(m_ap[k] >>> m_avg);
          m_am[k] = 0; m_ap[k] = 0;
        end
        m_nfr = 0;
        pub_q.push_back(cyc + 3);
        exp_mag_q.push_back(em);
        exp_ph_q.push_back(ep);
      end
      m_cnt = 0;
    end else begin
      m_cnt = ch + 1;
    end
  endtask

  // Every cycle: strobe_out/frame_err timing and output hold/update.
  always @(negedge sys_clk) begin
    bit exp_s, exp_e;
    if (!sys_rst && chk_en) begin
      exp_s = (pub_q.size() != 0) && (pub_q[0] == cyc);
      check("strobe_out", strobe_out, exp_s);
      if (exp_s) begin
        hold_mag = exp_mag_q.pop_front();
        hold_ph  = exp_ph_q.pop_front();
        void'(pub_q.pop_front());
      end
      check("mags", mags, hold_mag);
      check("phases", phases, hold_ph);
      exp_e = (err_q.size() != 0) && (err_q[0] == cyc);
      check("frame_err", frame_err, exp_e);
      if (exp_e) void'(err_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic first, input logic [MAG_W-1:0] mag,
                      input logic [PH_W-1:0] ph);
    @(posedge sys_clk); #1;
    strobe_in = 1'b1; first_in = first; mag_in = mag; phase_in = ph;
    model_step(first, mag, ph);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk); #1;
      strobe_in = 1'b0; first_in = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge sys_clk); #1;
    sys_rst = 1'b1; strobe_in = 1'b0; first_in = 1'b0;
    model_clear();
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
  endtask

  task automatic rand_frame();
    send(1'b1, MAG_W'($urandom), PH_W'($urandom));
    for (int k = 1; k < N_CH; k++) send(1'b0, MAG_W'($urandom), PH_W'($urandom));
  endtask

  // ---------------- stimulus ----------------
  logic [N_CH*PH_W-1:0]  e_ph;
  logic [N_CH*MAG_W-1:0] e_mag;
  logic [PH_W-1:0]       e_p1;
  logic [MAG_W-1:0]      e_m1;

  initial begin
    model_clear();
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    chk_en = 1'b1;
    #1;
    check("reset_mags", mags, '0);
    check("reset_phases", phases, '0);
    check("reset_strobe", {strobe_out, frame_err}, 2'b00);

    // Basic frame: mult ch3..1 = 5,4,3
    mult_factors = {4'd5, 4'd4, 4'd3};
    avg_log2 = 4'd0;
    send(1'b1, 21'd1, 22'd2);
    for (int k = 1; k < N_CH; k++) send(1'b0, 21'd1, 22'd2);
    idle(5);
    e_ph  = {PH_W'(-8), PH_W'(-6), PH_W'(-4), PH_W'(2)};
    e_mag = {4{21'd1}};
    check("basic_phases", phases, e_ph);
    check("basic_mags", mags, e_mag);

    // Modular wrap of the product, then mult=0 pass-through
    mult_factors = {4'd0, 4'd0, 4'd2};
    send(1'b1, 21'd0, 22'h100000);
    for (int k = 1; k < N_CH; k++) send(1'b0, 21'd0, 22'd0);
    idle(5);
    e_p1 = 22'h200000;
    check("wrap_phase1", phases[PH_W +: PH_W], e_p1);
    mult_factors = '0;
    send(1'b1, 21'd0, 22'h100000);
    for (int k = 1; k < N_CH; k++) send(1'b0, 21'd0, 22'd0);
    idle(5);
    check("mult0_phase1", phases[PH_W +: PH_W], '0);

    // Averaging over 4 frames
    avg_log2 = 4'd2;
    for (int f = 0; f < 4; f++) begin
      send(1'b1, 21'd0, 22'd0);
      send(1'b0, MAG_W'(10 + f), PH_W'((f == 0) ? -1 : (f == 3) ? -3 : -2));
      send(1'b0, 21'd0, 22'd0);
      send(1'b0, 21'd0, 22'd0);
      idle(f);
    end
    idle(5);
    e_m1 = 21'd11;
    e_p1 = PH_W'(-2);
    check("avg_mag1", mags[MAG_W +: MAG_W], e_m1);
    check("avg_phase1", phases[PH_W +: PH_W], e_p1);

    // Resync after a partial frame, and a stray strobe without first_in
    avg_log2 = 4'd0;
    mult_factors = {4'd1, 4'd2, 4'd3};
    send(1'b1, 21'd99, 22'd77);
    send(1'b0, 21'd55, 22'd33);
    rand_frame();
    idle(2);
    send(1'b0, 21'd123, 22'd456);
    rand_frame();
    idle(5);

    // Back-to-back frames
    for (int f = 0; f < 8; f++) rand_frame();
    idle(5);

    // Clamped depth: avg_log2=12 behaves as AVG_MAX
    avg_log2 = 4'd12;
    for (int f = 0; f < (1 << AVG_MAX); f++) rand_frame();
    idle(5);

    // Reset mid-block, then a full block
    avg_log2 = 4'd3;
    for (int f = 0; f < 5; f++) rand_frame();
    do_reset();
    for (int f = 0; f < 8; f++) rand_frame();
    idle(5);

    // Randomized mix
    for (int i = 0; i < 300; i++) begin
      int act;
      act = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) avg_log2 = 4'($urandom_range(0, 2));
      if (act == 0) begin
        idle(4);
        mult_factors = (N_CH-1)*MULT_W'($urandom);
      end else if (act == 1) begin
        send(1'b1, MAG_W'($urandom), PH_W'($urandom));
        for (int k = 1; k < $urandom_range(1, N_CH-1); k++)
          send(1'b0, MAG_W'($urandom), PH_W'($urandom));
      end else if (act == 2) begin
        send(1'b0, MAG_W'($urandom), PH_W'($urandom));
      end else begin
        rand_frame();
      end
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
    end
    idle(10);
    check("drain_pub", pub_q.size(), 0);
    check("drain_err", err_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_processor_n.md
Name: phase_processor_n

Overview:
- Parametrised successor to the fixed 4-channel VVM phase processor.
- Consumes the time-multiplexed magnitude/phase stream from the CORDIC, one sample per channel.
- Channel 0 is the reference. Outputs per-channel magnitude and reference-referred phase: phase[k] − mult[k]·phase[0], with two's-complement wrap.
- New over the previous generation: N_CH generic, explicit frame resync, and runtime-selectable boxcar averaging over 2^avg_log2 frames before publishing to CSRs.

Parameters:
- N_CH, 4, number of channels, including reference channel 0 (2..16).
- MAG_W, 21, magnitude width, unsigned.
- PH_W, 22, phase width, signed two's complement; full scale = ±π.
- MULT_W, 4, per-channel harmonic multiplier width, unsigned.
- AVG_MAX, 8, maximum avg_log2; also the accumulator headroom in bits.

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  synchronous reset, active high
- mag_in  in  MAG_W  magnitude sample
- phase_in  in  PH_W  phase sample
- strobe_in  in  1  qualifies mag_in/phase_in, one sample per pulse
- first_in  in  1  with strobe_in: this sample is channel 0
- mult_factors  in  (N_CH-1)*MULT_W  multiplier for channels 1..N_CH-1; channel k at bits [(k-1)*MULT_W +: MULT_W]
- avg_log2  in  4  averaging depth, 0..AVG_MAX; values above AVG_MAX are clamped
- mags  out  N_CH*MAG_W  averaged magnitudes, channel k at [k*MAG_W +: MAG_W]
- phases  out  N_CH*PH_W  averaged phases; channel 0 is the raw reference phase
- strobe_out  out  1  one-cycle pulse when mags/phases update
- frame_err  out  1  one-cycle pulse on a discarded partial frame

Behaviour:
- Reset: sys_rst is synchronous and active high. It clears mags, phases, strobe_out, frame_err, the channel counter, the frame counter and all accumulators. The channel counter expects channel 0 next.

Channel tracking:
- Each strobe_in advances a channel counter 0..N_CH-1.
- A strobe_in with first_in=1 forces the counter to 0.
- A strobe_in with first_in=0 while the counter expects 0 is dropped (not accumulated).

Resync:
- first_in arriving while counter ≠ 0 means a partial frame. The partial-frame contributions are discarded (accumulators restored to their block-start values) and frame_err pulses. This sample is then treated as channel 0.

Arithmetic:
- Channel 0: phase[0] latched.
- Channel k≥1, stage 1: prod = phase[0]·mult[k], signed × unsigned, truncated to PH_W (modular).
- Stage 2: diff = phase_in − prod, truncated to PH_W, so it wraps naturally at ±π.
- Stage 3: accumulate. Magnitude is zero-extended and phase is sign-extended to width+AVG_MAX.
- A single time-shared multiplier is used. Back-to-back strobes (1 per cycle) must be sustained.

Averaging:
- A block = 2^avg_log2 complete frames.
- avg_log2 is sampled at block start; changes mid-block take effect at the next block.
- avg_log2=0: every frame publishes.
- Publish values: mags = acc >> avg_log2 (logical shift); phases = acc >>> avg_log2 (arithmetic shift, truncated to PH_W). Accumulators clear for the next block in the same cycle.
- Phase averaging is linear. Values straddling ±π average incorrectly; this is documented and accepted.

Latency:
- strobe_out rises exactly 3 cycles after the strobe_in of channel N_CH-1 of the block's last frame.
- Outputs change only in the strobe_out cycle and hold otherwise.

Simultaneous events:
- sys_rst wins over everything.
- A new frame's channel 0 may arrive while the previous frame's pipeline drains; no stall and no loss.

mult_factors:
- Sampled at the channel-k stage-1 cycle.
- mult=0 yields phase[k] unmodified.

Test Plan:
- Defaults, avg_log2=0, mult={5,4,3} (ch3..1), frame mag=1 all, phase={2,2,2,2} → mags all 1; phases={2,−4,−6,−8}; strobe_out exactly 3 cycles after ch3 strobe.
- Wrap: phase0=0x100000, mult1=2, phase1=0 → phase1 = −0x200000 (modular wrap); mult1=0 → phase1=0.
- Averaging avg_log2=2, four frames with ch1 mag 10,11,12,13 → single strobe_out after frame 4, mag1=11 (floor 46/4). Negative phases −1,−2,−2,−3 → −2 (arithmetic shift).
- Resync: ch0, ch1, then first_in → frame_err pulse, no strobe_out. The next full frame publishes values unaffected by the partial one.
- Back-to-back: strobe_in every cycle for 8 frames, avg_log2=0 → 8 strobe_outs spaced N_CH cycles apart, all values correct.
- Reset mid-block (avg_log2=3, after 5 frames) → outputs zero next cycle. The next block needs a full 8 frames before strobe_out.
